hilo_ctrl: RTL and testbench

- EX-stage sequencer that sits between the decoded instruction and the multiply/divide unit.
- Drives the unit's control code, operands, enable and clear, and stalls the pipeline while a divide runs.
- Captures the 64-bit result and commits it, or an MTHI/MTLO value, into the architectural HI/LO registers when the instruction leaves EX unflushed.
- HI/LO outputs feed MFHI/MFLO selection in EX directly.

---
 rtl/hilo_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_hilo_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: EX-stage sequencer for the multiply/divide unit. Issues
// multiplies in a single cycle, stalls the pipeline while a divide runs,
// and commits results (or MTHI/MTLO values) to the architectural HI/LO.
module hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               flush,
  input  logic               advance,
  output logic [4:0]         mdu_control,
  output logic [WIDTH-1:0]   mdu_a,
  output logic [WIDTH-1:0]   mdu_b,
  output logic               mdu_en,
  output logic               mdu_clear,
  input  logic [2*WIDTH-1:0] mdu_result,
  input  logic               mdu_ready,
  output logic               stall,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  // Control codes understood by the multiply/divide unit
  localparam logic [4:0] MultCtl  = 5'b11000;
  localparam logic [4:0] MultuCtl = 5'b11001;
  localparam logic [4:0] DivCtl   = 5'b11010;
  localparam logic [4:0] DivuCtl  = 5'b11011;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [WIDTH-1:0]   opAQ;
  logic [WIDTH-1:0]   opBQ;
  logic [4:0]         ctlQ;
  logic [2*WIDTH-1:0] resQ;

  logic [4:0]         decodedCtl;
  logic               isDivOp;
  logic               latchDiv;
  logic               captureRes;
  logic               writeHi;
  logic               writeLo;
  logic [WIDTH-1:0]   hiNext;
  logic [WIDTH-1:0]   loNext;

  // Translate the instruction opcode into the unit's control code
  always_comb begin
    decodedCtl = 5'b0;
    case (op)
      OpMult:  decodedCtl = MultCtl;
      OpMultu: decodedCtl = MultuCtl;
      OpDiv:   decodedCtl = DivCtl;
      OpDivu:  decodedCtl = DivuCtl;
      default: decodedCtl = 5'b0;
    endcase
    isDivOp = op_valid && ((op == OpDiv) || (op == OpDivu));
  end

  // Next-state logic and all unit/pipeline control outputs
  always_comb begin
    nextState   = state;
    mdu_a       = rs_val;
    mdu_b       = rt_val;
    mdu_control = 5'b0;
    mdu_en      = 1'b0;
    mdu_clear   = 1'b0;
    stall       = 1'b0;
    latchDiv    = 1'b0;
    captureRes  = 1'b0;
    writeHi     = 1'b0;
    writeLo     = 1'b0;
    hiNext      = mdu_result[2*WIDTH-1:WIDTH];
    loNext      = mdu_result[WIDTH-1:0];

    case (state)
      IDLE: begin
        if (op_valid) begin
          mdu_control = decodedCtl;
        end
        if (isDivOp && !flush && (rt_val != '0)) begin
          stall     = 1'b1;
          latchDiv  = 1'b1;
          nextState = DIV_WAIT;
        end else if (op_valid && advance && !flush) begin
          case (op)
            OpMult, OpMultu: begin
              writeHi = 1'b1;
              writeLo = 1'b1;
            end
            OpMthi: begin
              writeHi = 1'b1;
              hiNext  = rs_val;
            end
            OpMtlo: begin
              writeLo = 1'b1;
              loNext  = rs_val;
            end
            default: ;
          endcase
        end
      end

      DIV_WAIT: begin
        mdu_a       = opAQ;
        mdu_b       = opBQ;
        mdu_control = ctlQ;
        mdu_en      = 1'b1;
        stall       = 1'b1;
        if (flush) begin
          mdu_clear = 1'b1;
          mdu_en    = 1'b0;
          stall     = 1'b0;
          nextState = IDLE;
        end else if (mdu_ready) begin
          captureRes = 1'b1;
          nextState  = HOLD;
        end
      end

      HOLD: begin
        if (flush) begin
          nextState = IDLE;
        end else if (advance) begin
          writeHi   = 1'b1;
          writeLo   = 1'b1;
          hiNext    = resQ[2*WIDTH-1:WIDTH];
          loNext    = resQ[WIDTH-1:0];
          nextState = IDLE;
        end
      end

      default: nextState = IDLE;
    endcase

    // While reset is held the unit is annulled and everything looks idle
    if (!rst) begin
      mdu_a       = rs_val;
      mdu_b       = rt_val;
      mdu_control = 5'b0;
      mdu_en      = 1'b0;
      mdu_clear   = 1'b1;
      stall       = 1'b0;
    end
  end

  // State, latched divide operands, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      opAQ  <= '0;
      opBQ  <= '0;
      ctlQ  <= 5'b0;
      resQ  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= nextState;
      if (latchDiv) begin
        opAQ <= rs_val;
        opBQ <= rt_val;
        ctlQ <= decodedCtl;
      end
      if (captureRes) begin
        resQ <= mdu_result;
      end
      if (writeHi) begin
        hi <= hiNext;
      end
      if (writeLo) begin
        lo <= loNext;
      end
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed bench for hilo_ctrl with a behavioural
// multiply/divide unit and a scoreboard of expected {HI,LO} commits.
module tb_hilo_ctrl;

  localparam logic [4:0] MultCtl  = 5'b11000;
  localparam logic [4:0] MultuCtl = 5'b11001;
  localparam logic [4:0] DivCtl   = 5'b11010;
  localparam logic [4:0] DivuCtl  = 5'b11011;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        advance;
  logic [4:0]  mdu_control;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_en;
  logic        mdu_clear;
  logic [63:0] mdu_result;
  logic        mdu_ready;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] expQ[$];
  int          divCnt;
  int          stallCycles;

  hilo_ctrl #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .op_valid(op_valid),
    .op(op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .flush(flush),
    .advance(advance),
    .mdu_control(mdu_control),
    .mdu_a(mdu_a),
    .mdu_b(mdu_b),
    .mdu_en(mdu_en),
    .mdu_clear(mdu_clear),
    .mdu_result(mdu_result),
    .mdu_ready(mdu_ready),
    .stall(stall),
    .hi(hi),
    .lo(lo)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider latency model: ready on the fifth consecutive enabled cycle
  always @(posedge clk) begin
    if (!rst || mdu_clear || !mdu_en) divCnt <= 0;
    else if (!mdu_ready) divCnt <= divCnt + 1;
  end
  assign mdu_ready = mdu_en && (divCnt == 4);

  // Behavioural multiply/divide result, {HI,LO} = {rem,quot} for divides
  always_comb begin
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] sa32;
    logic signed [31:0] sb32;
    sa   = {{32{mdu_a[31]}}, mdu_a};
    sb   = {{32{mdu_b[31]}}, mdu_b};
    sa32 = mdu_a;
    sb32 = mdu_b;
    mdu_result = 64'd0;
    case (mdu_control)
      MultCtl:  mdu_result = sa * sb;
      MultuCtl: mdu_result = {32'd0, mdu_a} * {32'd0, mdu_b};
      DivCtl:   if (mdu_b != 0) mdu_result = {32'(sa32 % sb32), 32'(sa32 / sb32)};
      DivuCtl:  if (mdu_b != 0) mdu_result = {mdu_a % mdu_b, mdu_a / mdu_b};
      default:  mdu_result = 64'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic adv, input logic fl);
    op_valid = v;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    advance  = adv;
    flush    = fl;
  endtask

  task automatic retireCheck(input string tag);
    logic [63:0] exp;
    if (expQ.size() == 0) exp = 64'hxxxx_xxxx_xxxx_xxxx;
    else exp = expQ.pop_front();
    checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
  endtask

  // Issue a divide and follow it until stall drops; returns at the
  // negative edge of the first non-stalled cycle
  task automatic runDivide(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] ctl, input logic adv, output int cycles);
    applyStimulus(1'b1, o, a, b, adv, 1'b0);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      cycles++;
      checkOutput("div_opA", {32'd0, mdu_a}, {32'd0, a});
      checkOutput("div_opB", {32'd0, mdu_b}, {32'd0, b});
      checkOutput("div_ctl", {59'd0, mdu_control}, {59'd0, ctl});
      @(posedge clk); #1;
      rs_val = 32'hDEAD_BEEF;
      rt_val = 32'h0BAD_F00D;
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_clear", {63'd0, mdu_clear}, 64'd1);
    checkOutput("rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_hi", {32'd0, hi}, 64'd0);
    checkOutput("rst_lo", {32'd0, lo}, 64'd0);
    checkOutput("rst_clear_off", {63'd0, mdu_clear}, 64'd0);

    // MULT -2 * 3
    @(posedge clk); #1;
    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    expQ.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    @(negedge clk);
    checkOutput("mult_stall", {63'd0, stall}, 64'd0);
    checkOutput("mult_ctl", {59'd0, mdu_control}, {59'd0, MultCtl});
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    retireCheck("mult");

    // MULTU 0xFFFFFFFF * 2
    applyStimulus(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    expQ.push_back({32'd1, 32'hFFFF_FFFE});
    @(negedge clk);
    checkOutput("multu_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    retireCheck("multu");

    // DIVU 100 / 7
    expQ.push_back({32'd2, 32'd14});
    runDivide(3'd4, 32'd100, 32'd7, DivuCtl, 1'b1, stallCycles);
    checkOutput("divu_stall_cycles", stallCycles, 64'd6);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    retireCheck("divu");

    // DIV -7 / 2 with advance held low in HOLD
    expQ.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runDivide(3'd3, 32'hFFFF_FFF9, 32'd2, DivCtl, 1'b0, stallCycles);
    checkOutput("div_stall_cycles", stallCycles, 64'd6);
    for (int k = 0; k < 3; k++) begin
      checkOutput("hold_hi", {32'd0, hi}, 64'd2);
      checkOutput("hold_lo", {32'd0, lo}, 64'd14);
      checkOutput("hold_stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    advance = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    retireCheck("div");

    // DIVU flushed on the third DIV_WAIT cycle
    applyStimulus(1'b1, 3'd4, 32'd50, 32'd3, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_c0_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("flush_w1_clear", {63'd0, mdu_clear}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_w3_clear", {63'd0, mdu_clear}, 64'd1);
    checkOutput("flush_w3_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush_after_clear", {63'd0, mdu_clear}, 64'd0);
    checkOutput("flush_after_stall", {63'd0, stall}, 64'd0);
    checkOutput("flush_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    checkOutput("flush_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);

    // MTLO after the flush
    @(posedge clk); #1;
    applyStimulus(1'b1, 3'd6, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
    expQ.push_back({32'hFFFF_FFFF, 32'h0000_1234});
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    retireCheck("mtlo");

    // Reset in the middle of DIV_WAIT
    applyStimulus(1'b1, 3'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_clear", {63'd0, mdu_clear}, 64'd1);
    checkOutput("midrst_stall", {63'd0, stall}, 64'd0);
    checkOutput("midrst_en", {63'd0, mdu_en}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postrst_stall", {63'd0, stall}, 64'd0);
    checkOutput("postrst_en", {63'd0, mdu_en}, 64'd0);
    checkOutput("postrst_hi", {32'd0, hi}, 64'd0);
    checkOutput("postrst_lo", {32'd0, lo}, 64'd0);

    // DIV by zero retires without stalling and leaves HI/LO alone
    @(posedge clk); #1;
    applyStimulus(1'b1, 3'd3, 32'd55, 32'd0, 1'b1, 1'b0);
    expQ.push_back(64'd0);
    @(negedge clk);
    checkOutput("div0_stall", {63'd0, stall}, 64'd0);
    checkOutput("div0_en", {63'd0, mdu_en}, 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("div0_next_stall", {63'd0, stall}, 64'd0);
    retireCheck("div0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
